// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized, mid-bit sampled, LSB first,
// single-entry valid/ready output register with framing-error and overrun pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in__rx,
    output logic [7:0] out__data,
    output logic       out__valid,
    input  logic       in__ready,
    output logic       out__frame_err,
    output logic       out__overrun
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        r_state;
    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shreg;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_frame_err;
    logic          r_overrun;

    logic w_rx_s;
    logic w_tick;

    assign w_rx_s = r_sync2;
    assign w_tick = (r_cnt == '0);

    // NOTE: all state here uses non-blocking assignments so every register
    // updates from pre-edge values; later assignments in the block win.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // Synchronizer resets to the idle level so release never looks like a start bit.
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shreg     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync1     <= in__rx;
            r_sync2     <= r_sync1;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;

            if (r_valid && in__ready)
                r_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= CNT_HALF;
                    end
                end
                S_START: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_DATA;
                        r_idx   <= '0;
                        r_cnt   <= CNT_BIT;
                    end
                end
                S_DATA: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_shreg <= {w_rx_s, r_shreg[7:1]};
                        r_cnt   <= CNT_BIT;
                        if (r_idx == 3'd7)
                            r_state <= S_STOP;
                        else
                            r_idx <= r_idx + 1'b1;
                    end
                end
                S_STOP: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_rx_s) begin
                        r_state <= S_IDLE;
                        // A same-cycle handshake frees the register for the new byte.
                        if (!r_valid || in__ready) begin
                            r_data  <= r_shreg;
                            r_valid <= 1'b1;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                    end else begin
                        r_frame_err <= 1'b1;
                        r_state     <= S_BREAK;
                    end
                end
                S_BREAK: begin
                    if (w_rx_s)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out__data      = r_data;
    assign out__valid     = r_valid;
    assign out__frame_err = r_frame_err;
    assign out__overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: expected bytes are queued as frames are sent
// and compared when the receiver hands a byte over.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       in__rx;
    logic [7:0] out__data;
    logic       out__valid;
    logic       in__ready;
    logic       out__frame_err;
    logic       out__overrun;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk            (clk),
        .rst            (rst),
        .in__rx         (in__rx),
        .out__data      (out__data),
        .out__valid     (out__valid),
        .in__ready      (in__ready),
        .out__frame_err (out__frame_err),
        .out__overrun   (out__overrun)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_valid = 0;
    int n_fe    = 0;
    int n_ov    = 0;
    int rise_cyc = -1;
    int fe_cyc   = -1;
    int ov_cyc   = -1;
    logic prev_valid = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (out__valid) n_valid++;
        if (out__valid && !prev_valid) rise_cyc = cyc;
        prev_valid = out__valid;
        if (out__frame_err) begin n_fe++; fe_cyc = cyc; end
        if (out__overrun) begin n_ov++; ov_cyc = cyc; end
        if (out__frame_err || out__overrun)
            check("flags_exclusive", 32'(out__frame_err & out__overrun), 32'd0);
        if (out__valid && in__ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $error("FAIL unexpected_byte: observed %0h expected none", out__data);
            end else begin
                check("rx_data", 32'(out__data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame starting now; e0 is the edge number that first captures the start bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, output int e0);
        in__rx = 1'b0;
        e0 = cyc + 1;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            in__rx = b[i];
            hold(CPB);
        end
        in__rx = stop;
        hold(CPB);
        in__rx = 1'b1;
    endtask

    initial begin
        int e0, e1, nv, fe0, ov0;

        // 1. reset and idle line
        rst = 1'b0; in__rx = 1'b1; in__ready = 1'b0;
        hold(3);
        check("rst_valid", 32'(out__valid), 32'd0);
        check("rst_data", 32'(out__data), 32'd0);
        check("rst_flags", 32'({out__frame_err, out__overrun}), 32'd0);
        rst = 1'b1;
        hold(200);
        check("idle_valid", 32'(n_valid), 32'd0);
        check("idle_fe", 32'(n_fe), 32'd0);
        check("idle_ov", 32'(n_ov), 32'd0);

        // 2. single frame 0xA5, latency and one-cycle valid
        in__ready = 1'b1;
        nv = n_valid;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, e0);
        hold(20);
        check("t2_latency", 32'(rise_cyc - e0), 32'd154);
        check("t2_valid_cycles", 32'(n_valid - nv), 32'd1);

        // 3. short glitch rejected, then 0x3C
        nv = n_valid;
        in__rx = 1'b0;
        hold(3);
        in__rx = 1'b1;
        hold(30);
        check("t3_glitch_valid", 32'(n_valid - nv), 32'd0);
        check("t3_glitch_flags", 32'(n_fe + n_ov), 32'd0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, e0);
        hold(20);
        check("t3_valid_cycles", 32'(n_valid - nv), 32'd1);

        // 4. framing error with held-low line, then 0x5A
        nv = n_valid; fe0 = n_fe;
        send_frame(8'h3C, 1'b0, e0);
        in__rx = 1'b0;
        hold(50);
        in__rx = 1'b1;
        hold(20);
        check("t4_fe_count", 32'(n_fe - fe0), 32'd1);
        check("t4_fe_cycle", 32'(fe_cyc - e0), 32'd154);
        check("t4_no_valid", 32'(n_valid - nv), 32'd0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, e0);
        hold(20);
        check("t4_valid_cycles", 32'(n_valid - nv), 32'd1);
        check("t4_fe_after", 32'(n_fe - fe0), 32'd1);

        // 5. back-to-back frames with consumer stalled -> overrun
        in__ready = 1'b0;
        ov0 = n_ov;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, e0);
        send_frame(8'h22, 1'b1, e1);
        hold(10);
        check("t5_b2b_spacing", 32'(e1 - e0), 32'd160);
        check("t5_valid_held", 32'(out__valid), 32'd1);
        check("t5_data_held", 32'(out__data), 32'h11);
        check("t5_ov_count", 32'(n_ov - ov0), 32'd1);
        check("t5_ov_cycle", 32'(ov_cyc - e1), 32'd154);
        in__ready = 1'b1;
        hold(1);
        check("t5_valid_drop", 32'(out__valid), 32'd0);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // 6. reset during data bit 4 of 0x81, then a clean 0x81
        nv = n_valid; fe0 = n_fe; ov0 = n_ov;
        in__rx = 1'b0;
        hold(CPB);
        for (int i = 0; i < 4; i++) begin
            in__rx = (i == 0);
            hold(CPB);
        end
        in__rx = 1'b0;
        hold(8);
        rst = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out__valid), 32'd0);
        check("t6_rst_data", 32'(out__data), 32'd0);
        check("t6_rst_flags", 32'({out__frame_err, out__overrun}), 32'd0);
        hold(3);
        in__rx = 1'b1;
        hold(2);
        rst = 1'b1;
        hold(40);
        check("t6_no_partial", 32'(n_valid - nv), 32'd0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, e0);
        hold(20);
        check("t6_valid_cycles", 32'(n_valid - nv), 32'd1);
        check("t6_no_flags", 32'((n_fe - fe0) + (n_ov - ov0)), 32'd0);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
